// File: rtl/text_overlay_write_scheduler.sv
// text_overlay_write_scheduler: round-robin owner of the character-RAM write port,
// streaming one character per clock of the winning text box during vertical blanking.
module text_overlay_write_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_CHAR = 16,
    parameter int ADDR_W   = $clog2(NUM_REQ*MAX_CHAR),
    parameter int LEN_W    = $clog2(MAX_CHAR+1)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_vblank,
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [NUM_REQ*LEN_W-1:0]     i_len,
    input  logic [NUM_REQ*MAX_CHAR*8-1:0] i_chars,
    output logic [NUM_REQ-1:0]           o_grant,
    output logic [NUM_REQ-1:0]           o_done,
    output logic                         o_wr_en,
    output logic [ADDR_W-1:0]            o_wr_addr,
    output logic [7:0]                   o_wr_data,
    output logic                         o_busy
);
    localparam int OW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int IW = MAX_CHAR > 1 ? $clog2(MAX_CHAR) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t            r_state;
    logic [OW-1:0]     r_rr_ptr;
    logic [OW-1:0]     r_owner;
    logic [IW-1:0]     r_idx;
    logic [LEN_W-1:0]  r_len;
    logic [OW-1:0]     w_winner;
    logic [OW:0]       w_cand;
    logic              w_found;
    logic [LEN_W-1:0]  w_len_raw;
    logic [LEN_W-1:0]  w_len;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_addr;

    // Search starts at the round-robin pointer and wraps modulo NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_cand = {1'b0, r_rr_ptr} + (OW+1)'(j);
            if (w_cand >= (OW+1)'(NUM_REQ))
                w_cand = w_cand - (OW+1)'(NUM_REQ);
            if (!w_found && i_req[w_cand[OW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[OW-1:0];
            end
        end
    end

    assign w_len_raw = i_len[w_winner*LEN_W +: LEN_W];
    assign w_len     = w_len_raw > LEN_W'(MAX_CHAR) ? LEN_W'(MAX_CHAR) : w_len_raw;
    assign w_wr_en   = (r_state == WRITE) && i_vblank;
    assign w_addr    = ADDR_W'(r_owner) * ADDR_W'(MAX_CHAR) + ADDR_W'(r_idx);

    assign o_wr_en   = w_wr_en;
    assign o_wr_addr = r_state == WRITE ? w_addr : '0;
    assign o_wr_data = r_state == WRITE ? i_chars[w_addr*8 +: 8] : '0;
    assign o_grant   = r_state != IDLE ? NUM_REQ'(1) << r_owner : '0;
    assign o_done    = r_state == DONE ? NUM_REQ'(1) << r_owner : '0;
    assign o_busy    = r_state != IDLE;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_idx    <= '0;
            r_len    <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_vblank && w_found) begin
                    r_owner  <= w_winner;
                    r_len    <= w_len;
                    r_idx    <= '0;
                    r_rr_ptr <= w_winner == OW'(NUM_REQ-1) ? '0 : w_winner + 1'b1;
                    r_state  <= w_len == '0 ? DONE : WRITE;
                end
                // Index only moves on real write strobes, so a vblank gap just pauses.
                WRITE: if (w_wr_en) begin
                    r_idx <= r_idx + 1'b1;
                    if (LEN_W'(r_idx) == r_len - 1'b1)
                        r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/text_overlay_write_scheduler.md
Name: text_overlay_write_scheduler

Overview:
- Shares the single character-RAM write port of the text overlay between NUM_REQ text-box requesters, e.g. a status line, an FPS counter and a debug string.
- Arbitrates round-robin and streams the winner's string into the RAM one character per clock.
- Writes only during vertical blanking, so a box never tears mid-frame.
- Sits in the pixel-clock domain, between the string producers and the overlay's character buffer.

Parameters:
- NUM_REQ, 4, number of requesters.
- MAX_CHAR, 16, character slots reserved per requester.
- ADDR_W, $clog2(NUM_REQ*MAX_CHAR), width of the character-RAM write address.
- LEN_W, $clog2(MAX_CHAR+1), width of each length field.

Ports:
- i_clk  in  1  pixel clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_vblank  in  1  high while the video timing is in vertical blanking.
- i_req  in  NUM_REQ  per-requester write request (level).
- i_len  in  NUM_REQ*LEN_W  string length; requester k at [k*LEN_W +: LEN_W].
- i_chars  in  NUM_REQ*MAX_CHAR*8  ASCII; char i of requester k at [(k*MAX_CHAR+i)*8 +: 8].
- o_grant  out  NUM_REQ  one-hot; identifies the owner of the current transfer.
- o_done  out  NUM_REQ  one-cycle pulse on the owner's bit when its transfer completes.
- o_wr_en  out  1  character-RAM write strobe.
- o_wr_addr  out  ADDR_W  character-RAM address.
- o_wr_data  out  8  character code.
- o_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE, rr_ptr=0, owner=0, idx=0.
  - All outputs 0 immediately, independent of i_clk.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - Arbitration happens only when i_vblank=1 and |i_req.
  - Winner = first set i_req bit searching k = rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - On the arbitration edge: latch owner=winner, len=min(i_len[owner], MAX_CHAR), idx=0, rr_ptr=(winner+1) mod NUM_REQ.
  - Next state is WRITE if len>0, else DONE.
- WRITE:
  - o_wr_en = i_vblank (the only combinational output term).
  - o_wr_addr = owner*MAX_CHAR + idx.
  - o_wr_data = i_chars char idx of owner.
  - idx advances only on cycles with o_wr_en=1.
  - When idx==len-1 and o_wr_en=1, next state is DONE.
  - When i_vblank=0, the transfer pauses: idx holds, o_wr_en=0, addr and data hold. It resumes on the next blanking period.
- DONE:
  - Lasts one cycle: o_done[owner]=1, o_wr_en=0, then IDLE.
- o_grant[owner]=1 in WRITE and DONE, 0 in IDLE. o_busy = (state!=IDLE).
- Timing, with i_vblank steadily high and arbitration at edge N:
  - writes on cycles N+1..N+L;
  - DONE on cycle N+L+1;
  - IDLE on cycle N+L+2, which is the earliest arbitration;
  - the next grant is visible on cycle N+L+3.
  - L=0: DONE on cycle N+1, no write strobe.
- Lengths greater than MAX_CHAR are clamped to MAX_CHAR. Never write outside the owner's slot range.
- Requester contract: i_len and i_chars of the owner are held stable from the request until o_done.
- Dropping i_req mid-transfer is ignored; the transfer completes and o_done still pulses.
- An i_req still high after o_done is a new request. Round-robin order means other pending requesters win first.
- No ready/valid from the RAM: the port is assumed to accept one write per cycle.

Test Plan:
- Reset mid-WRITE (assert i_rst asynchronously between clock edges):
  - all outputs go to 0 before the next i_clk edge;
  - after release with i_req=4'b0001 and vblank, requester 0 restarts at idx=0 and address 0.
- Single request, i_req=4'b0010, len=5, "HELLO", vblank high:
  - grant[1] on N+1..N+6;
  - writes to addresses 16..20 with data 0x48,0x45,0x4C,0x4C,0x4F;
  - o_done=4'b0010 on N+6 only.
- Round-robin, i_req=4'b1111 held, each len=1:
  - grant order 0,1,2,3,0;
  - each transfer occupies 3 cycles, giving a grant every 3 cycles (o_busy low one cycle between transfers).
- vblank pause, requester 2, len=8, i_vblank dropped after 3 writes for 10 cycles:
  - o_wr_en=0 while low, and o_wr_addr holds 35 (not yet written);
  - on resume, writes 35..39 follow;
  - total 8 writes.
- Boundary lengths:
  - len=0 gives grant plus o_done on N+1 and zero writes;
  - i_len=31 on requester 3 is clamped to 16, writing addresses 48..63 only.
- i_vblank=0 with requests pending: no grant and no writes for any duration; arbitration occurs on the first edge with i_vblank=1.
